ls_mem_issue_arbiter: RTL and testbench

- Shares the single data-memory pipeline between NREQ load/store reservation-station issue ports.
- The RS issue ports have no backpressure, so each port gets a small FIFO. The block raises a per-port stall early enough for the RS to stop dispatch (deassert start).
- Grants are round-robin across ports; order within a port is preserved. Output is a registered valid/ready interface to the memory stage.
- Flushed by exception_sig or mret_sig, in step with the reservation stations.

---
 rtl/ls_pkg.sv | 13 +
 rtl/ls_arb_fifo.sv | 53 +++++
 rtl/ls_mem_issue_arbiter.sv | 111 +++++++++++
 tb/tb_ls_mem_issue_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared load/store issue packet layout for the memory issue arbiter and its users.
package ls_pkg;

  localparam int unsigned LS_PKT_W     = 100;
  localparam int unsigned LS_IMM_LSB   = 0;
  localparam int unsigned LS_IMM_W     = 32;
  localparam int unsigned LS_VALID_BIT = 51;
  localparam int unsigned LS_INST_LSB  = 52;
  localparam int unsigned LS_INST_W    = 32;
  localparam int unsigned LS_OP1_LSB   = 84;
  localparam int unsigned LS_OPND_W    = 8;

endpackage

// File: rtl/ls_arb_fifo.sv
// Per-port issue FIFO. A push on a full FIFO only lands when the same edge pops.
module ls_arb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 100,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ls_mem_issue_arbiter.sv
// Round-robin arbiter sharing the data-memory pipeline between load/store issue ports.
module ls_mem_issue_arbiter
  import ls_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PKT_W = LS_PKT_W,
  localparam int unsigned SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exception_sig,
  input  logic                  mret_sig,
  input  logic [NREQ*PKT_W-1:0] req_pkt,
  output logic [NREQ-1:0]       req_stall,
  output logic [NREQ-1:0]       req_overflow,
  output logic [PKT_W-1:0]      out_pkt,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      out_src,
  input  logic                  mem_ready,
  output logic [NREQ*CW-1:0]    fifo_count
);

  logic             flush;
  logic [NREQ-1:0]  push, pop, full, empty;
  logic [PKT_W-1:0] head [NREQ];
  logic [CW-1:0]    cnt [NREQ];

  logic [PKT_W-1:0] out_pkt_q;
  logic             out_valid_q;
  logic [SEL_W-1:0] out_src_q, rr_ptr_q;
  logic [NREQ-1:0]  overflow_q;

  logic             free, found;
  logic [SEL_W-1:0] sel, sel_next;

  assign flush = exception_sig | mret_sig;

  for (genvar g = 0; g < NREQ; g++) begin : g_port
    assign push[g] = req_pkt[g*PKT_W + LS_VALID_BIT];

    ls_arb_fifo #(
      .DEPTH (DEPTH),
      .W     (PKT_W)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (req_pkt[g*PKT_W +: PKT_W]),
      .dout  (head[g]),
      .count (cnt[g]),
      .full  (full[g]),
      .empty (empty[g])
    );

    assign fifo_count[g*CW +: CW] = cnt[g];
    // Two slots of headroom absorb the packet already in flight from the RS.
    assign req_stall[g] = (cnt[g] >= CW'(DEPTH - 2));
  end

  assign free = !out_valid_q || mem_ready;

  always_comb begin
    int unsigned idx;
    found    = 1'b0;
    sel      = '0;
    sel_next = '0;
    pop      = '0;
    idx      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = SEL_W'(idx);
      end
    end
    sel_next = SEL_W'((int'(sel) + 1) % NREQ);
    if (free && found) pop[sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      out_pkt_q   <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
      rr_ptr_q    <= '0;
      overflow_q  <= '0;
    end else begin
      if (free) begin
        if (found) begin
          out_pkt_q   <= head[sel];
          out_valid_q <= 1'b1;
          out_src_q   <= sel;
          rr_ptr_q    <= sel_next;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      overflow_q <= overflow_q | (push & full & ~pop);
    end
  end

  assign out_pkt      = out_pkt_q;
  assign out_valid    = out_valid_q;
  assign out_src      = out_src_q;
  assign req_overflow = overflow_q;

endmodule

// File: tb/tb_ls_mem_issue_arbiter.sv
// Self-checking bench for ls_mem_issue_arbiter: cycle vector table plus scoreboarded sequences.
module tb_ls_mem_issue_arbiter;
  import ls_pkg::*;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PKT_W = LS_PKT_W;
  localparam int unsigned CW    = 3;

  logic                  clk;
  logic                  reset;
  logic                  exception_sig;
  logic                  mret_sig;
  logic [NREQ*PKT_W-1:0] req_pkt;
  logic [NREQ-1:0]       req_stall;
  logic [NREQ-1:0]       req_overflow;
  logic [PKT_W-1:0]      out_pkt;
  logic                  out_valid;
  logic                  out_src;
  logic                  mem_ready;
  logic [NREQ*CW-1:0]    fifo_count;

  ls_mem_issue_arbiter #(
    .NREQ  (NREQ),
    .DEPTH (DEPTH),
    .PKT_W (PKT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .exception_sig (exception_sig),
    .mret_sig      (mret_sig),
    .req_pkt       (req_pkt),
    .req_stall     (req_stall),
    .req_overflow  (req_overflow),
    .out_pkt       (out_pkt),
    .out_valid     (out_valid),
    .out_src       (out_src),
    .mem_ready     (mem_ready),
    .fifo_count    (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];
  logic [31:0] got_q  [$];
  logic [31:0] want_q [$];
  logic [31:0] mon_e;
  bit          mon_have;

  typedef struct packed {
    logic        v0;
    logic [31:0] i0;
    logic        v1;
    logic [31:0] i1;
    logic        rdy;
    logic        ov;
    logic [31:0] inst;
    logic        src;
    logic [2:0]  c0;
    logic [2:0]  c1;
    logic [1:0]  stall;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [PKT_W-1:0] mk_pkt(input logic [31:0] inst);
    logic [PKT_W-1:0] p;
    p = '0;
    p[LS_IMM_LSB +: LS_IMM_W]  = inst * 32'd7 + 32'd3;
    p[LS_VALID_BIT]            = 1'b1;
    p[LS_INST_LSB +: LS_INST_W] = inst;
    p[LS_OP1_LSB +: LS_OPND_W] = inst[7:0] ^ 8'h5a;
    return p;
  endfunction

  function automatic vec_t mkv(input logic v0, input int i0, input logic v1, input int i1,
                               input logic rdy, input logic ov, input int inst, input logic src,
                               input int c0, input int c1, input logic [1:0] stall);
    vec_t v;
    v.v0 = v0;  v.i0 = i0;  v.v1 = v1;  v.i1 = i1;  v.rdy = rdy;
    v.ov = ov;  v.inst = inst;  v.src = src;
    v.c0 = 3'(c0);  v.c1 = 3'(c1);  v.stall = stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input int i0, input logic v1, input int i1,
                       input logic rdy);
    req_pkt[0 +: PKT_W]     = v0 ? mk_pkt(i0) : '0;
    req_pkt[PKT_W +: PKT_W] = v1 ? mk_pkt(i1) : '0;
    mem_ready = rdy;
    if (v0) exp_q0.push_back(i0);
    if (v1) exp_q1.push_back(i1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    repeat (n) tick();
  endtask

  task automatic chk_seq(input string name);
    chk({name, "_len"}, got_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < got_q.size(); i++)
      chk({name, "_item"}, got_q[i], want_q[i]);
  endtask

  // Scoreboard: every transfer must match the oldest outstanding packet of its source.
  always @(negedge clk) begin
    if (reset && !exception_sig && !mret_sig && out_valid && mem_ready) begin
      got_q.push_back(out_pkt[LS_INST_LSB +: LS_INST_W]);
      mon_have = 1'b0;
      if (out_src == 1'b0 && exp_q0.size() > 0) begin
        mon_e = exp_q0.pop_front();
        mon_have = 1'b1;
      end else if (out_src == 1'b1 && exp_q1.size() > 0) begin
        mon_e = exp_q1.pop_front();
        mon_have = 1'b1;
      end
      if (!mon_have) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got inst %0d from src %0d, required no transfer",
                 out_pkt[LS_INST_LSB +: LS_INST_W], out_src);
      end else begin
        chk("sb_pkt", out_pkt, mk_pkt(mon_e));
      end
    end
  end

  task automatic flush_test(input bit use_exc);
    drive(1'b1, 40, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 41, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 42, 1'b0, 0, 1'b0); tick();
    drive(1'b1, 43, 1'b0, 0, 1'b0); tick();
    chk("flush_pre_valid", out_valid, 1'b1);
    chk("flush_pre_c0", fifo_count[2:0], 3'd3);
    exp_q0.delete(); exp_q1.delete();
    drive(1'b1, 44, 1'b0, 0, 1'b1);
    exp_q0.delete();
    exception_sig = use_exc;
    mret_sig      = !use_exc;
    tick();
    exception_sig = 1'b0;
    mret_sig      = 1'b0;
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_counts", fifo_count, 6'd0);
    chk("flush_pkt", out_pkt, '0);
    chk("flush_src", out_src, 1'b0);
    chk("flush_ovf", req_overflow, 2'b00);
    got_q.delete();
    drive(1'b1, 60, 1'b1, 50, 1'b1); tick();
    chk("flush_c0_no_stale", fifo_count[2:0], 3'd1);
    chk("flush_c1", fifo_count[5:3], 3'd1);
    chk("flush_post_valid", out_valid, 1'b0);
    drive(1'b0, 0, 1'b0, 0, 1'b1); tick();
    chk("flush_rr_src", out_src, 1'b0);
    chk("flush_rr_inst", out_pkt[LS_INST_LSB +: LS_INST_W], 32'd60);
    idle(4);
    want_q = '{32'd60, 32'd50};
    chk_seq("flush_seq");
  endtask

  initial begin
    tbl[0]  = mkv(1, 10, 1, 20, 0,  0,  0, 0,  1, 1, 2'b00);
    tbl[1]  = mkv(1, 11, 1, 21, 0,  1, 10, 0,  1, 2, 2'b10);
    tbl[2]  = mkv(1, 12, 1, 22, 0,  1, 10, 0,  2, 3, 2'b11);
    tbl[3]  = mkv(0,  0, 0,  0, 1,  1, 20, 1,  2, 2, 2'b11);
    tbl[4]  = mkv(0,  0, 0,  0, 1,  1, 11, 0,  1, 2, 2'b10);
    tbl[5]  = mkv(0,  0, 0,  0, 1,  1, 21, 1,  1, 1, 2'b00);
    tbl[6]  = mkv(0,  0, 0,  0, 1,  1, 12, 0,  0, 1, 2'b00);
    tbl[7]  = mkv(0,  0, 0,  0, 1,  1, 22, 1,  0, 0, 2'b00);
    tbl[8]  = mkv(0,  0, 0,  0, 1,  0, 22, 1,  0, 0, 2'b00);
    tbl[9]  = mkv(1,  1, 0,  0, 1,  0, 22, 1,  1, 0, 2'b00);
    tbl[10] = mkv(1,  2, 0,  0, 1,  1,  1, 0,  1, 0, 2'b00);
    tbl[11] = mkv(1,  3, 0,  0, 1,  1,  2, 0,  1, 0, 2'b00);
    tbl[12] = mkv(0,  0, 0,  0, 1,  1,  3, 0,  0, 0, 2'b00);
    tbl[13] = mkv(0,  0, 0,  0, 1,  0,  3, 0,  0, 0, 2'b00);

    reset = 1'b0;
    exception_sig = 1'b0;
    mret_sig = 1'b0;
    drive(1'b1, 90, 1'b1, 91, 1'b1);
    repeat (3) tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_counts", fifo_count, 6'd0);
    chk("rst_ovf", req_overflow, 2'b00);
    chk("rst_stall", req_stall, 2'b00);
    chk("rst_pkt", out_pkt, '0);
    exp_q0.delete(); exp_q1.delete();
    drive(1'b0, 0, 1'b0, 0, 1'b1);
    reset = 1'b1;
    tick(); tick();
    chk("rst_idle_valid", out_valid, 1'b0);

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v0, tbl[i].i0, tbl[i].v1, tbl[i].i1, tbl[i].rdy);
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_inst", i), out_pkt[LS_INST_LSB +: LS_INST_W], tbl[i].inst);
      chk($sformatf("vec%0d_src", i), out_src, tbl[i].src);
      chk($sformatf("vec%0d_c0", i), fifo_count[2:0], tbl[i].c0);
      chk($sformatf("vec%0d_c1", i), fifo_count[5:3], tbl[i].c1);
      chk($sformatf("vec%0d_stall", i), req_stall, tbl[i].stall);
      chk($sformatf("vec%0d_ovf", i), req_overflow, 2'b00);
    end

    // Backpressure on port 1: one packet in the output register, four queued, sixth dropped.
    got_q.delete();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 0, 1'b1, 30 + i, 1'b0);
      if (i == 5) void'(exp_q1.pop_back());
      tick();
      chk("bp_c1", fifo_count[5:3], (i == 0) ? 3'd1 : 3'((i < 5) ? i : 4));
      chk("bp_stall1", req_stall[1], i >= 2);
      if (i >= 1) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_inst", out_pkt[LS_INST_LSB +: LS_INST_W], 32'd30);
        chk("bp_hold_src", out_src, 1'b1);
      end
    end
    chk("bp_ovf", req_overflow, 2'b10);
    idle(7);
    want_q = '{32'd30, 32'd31, 32'd32, 32'd33, 32'd34};
    chk_seq("bp_seq");
    chk("bp_ovf_sticky", req_overflow, 2'b10);

    flush_test(1'b0);
    flush_test(1'b1);

    // Port 0 full, then push while the output drains it.
    got_q.delete();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 70 + i, 1'b0, 0, 1'b0);
      tick();
    end
    chk("full_c0", fifo_count[2:0], 3'd4);
    for (int i = 5; i < 7; i++) begin
      drive(1'b1, 70 + i, 1'b0, 0, 1'b1);
      tick();
      chk("full_pp_c0", fifo_count[2:0], 3'd4);
      chk("full_pp_ovf", req_overflow, 2'b00);
    end
    idle(8);
    want_q = '{32'd70, 32'd71, 32'd72, 32'd73, 32'd74, 32'd75, 32'd76};
    chk_seq("full_seq");
    chk("full_drained", fifo_count, 6'd0);
    chk("sb_q0_empty", exp_q0.size(), 0);
    chk("sb_q1_empty", exp_q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
